// File: rtl/reg_dump_sequencer.sv
// Debug register dump: sweeps the register bank and streams each word MSB byte first to the UART TX.
// Optional REG_DUMP_CHECKSUM_EN appends a running XOR of all data bytes as one trailing byte.
module reg_dump_sequencer #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned REG_SIZE  = 5,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYTE_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_rb_data,
  input  logic                 i_tx_done,
  output logic                 o_rb_enable,
  output logic                 o_rb_read_enable,
  output logic [REG_SIZE-1:0]  o_rb_read_addr,
  output logic                 o_tx_start,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BYTES = DATA_SIZE / BYTE_SIZE;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_NEXT,
    S_DONE
`ifdef REG_DUMP_CHECKSUM_EN
    , S_CHKSUM
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [REG_SIZE-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] cap_q, cap_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [BYTE_SIZE-1:0] chk_q, chk_d;
  logic                 chk_phase_q, chk_phase_d;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q       <= '0;
      chk_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q       <= chk_d;
      chk_phase_q <= chk_phase_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
`ifdef REG_DUMP_CHECKSUM_EN
    chk_d       = chk_q;
    chk_phase_d = chk_phase_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_READ;
          addr_d      = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          chk_d       = '0;
          chk_phase_d = 1'b0;
`endif
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        cap_d   = i_rb_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
`ifdef REG_DUMP_CHECKSUM_EN
        if (!chk_phase_q) chk_d = chk_q ^ cap_q[DATA_SIZE-1 -: BYTE_SIZE];
`endif
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (cnt_q < CNT_W'(BYTES - 1)) begin
            cap_d   = cap_q << BYTE_SIZE;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SEND;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = chk_phase_q ? S_DONE : S_NEXT;
`else
            state_d = S_NEXT;
`endif
          end
        end
      end
      S_NEXT: begin
        if (addr_q == REG_SIZE'(NUM_REGS - 1)) begin
`ifdef REG_DUMP_CHECKSUM_EN
          state_d = S_CHKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_READ;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      // Checksum reuses SEND/WAIT_TX: placed in the top byte with the counter preset to the last byte.
      S_CHKSUM: begin
        cap_d                           = '0;
        cap_d[DATA_SIZE-1 -: BYTE_SIZE] = chk_q;
        cnt_d                           = CNT_W'(BYTES - 1);
        chk_phase_d                     = 1'b1;
        state_d                         = S_SEND;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy           = (state_q != S_IDLE);
    o_rb_enable      = o_busy;
    o_rb_read_enable = (state_q == S_READ);
    o_rb_read_addr   = addr_q;
    o_tx_start       = (state_q == S_SEND);
    o_done           = (state_q == S_DONE);
    o_tx_data        = '0;
    if (state_q == S_SEND || state_q == S_WAIT_TX) o_tx_data = cap_q[DATA_SIZE-1 -: BYTE_SIZE];
  end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer with a register bank model and a UART TX responder.
module tb_reg_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] rb_data;
  logic        tx_done;
  logic        o_rb_enable, o_rb_read_enable, o_tx_start, o_busy, o_done;
  logic [4:0]  o_rb_read_addr;
  logic [7:0]  o_tx_data;

  logic [31:0] regs [32];
  logic [7:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          bytes_seen = 0;
  int          done_cnt = 0;
  bit          tx_auto = 1'b1;
  int          tx_req = 0;

  reg_dump_sequencer #(.DATA_SIZE(32), .REG_SIZE(5), .NUM_REGS(32), .BYTE_SIZE(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_rb_data(rb_data), .i_tx_done(tx_done),
    .o_rb_enable(o_rb_enable), .o_rb_read_enable(o_rb_read_enable), .o_rb_read_addr(o_rb_read_addr),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register bank: data valid in the cycle after the READ cycle.
  initial begin
    rb_data = '0;
    forever begin
      @(negedge clk);
      if (o_rb_read_enable) rb_data = regs[o_rb_read_addr];
    end
  end

  // UART TX responder: auto pulse 5 cycles after each start, plus on-demand pulses.
  initial begin
    int tx_cnt = 0;
    int tx_ack = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (tx_req != tx_ack) begin
        tx_done = 1'b1;
        tx_ack  = tx_req;
      end
      if (tx_auto) begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (o_tx_start) tx_cnt = 5;
      end else tx_cnt = 0;
    end
  end

  // Monitor: address sweep, first-byte latency, byte scoreboard, done pulses.
  initial begin
    int  mon_addr = 0;
    bit  first = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!o_busy) begin
        mon_addr = 0;
        first    = 1'b1;
      end
      if (o_rb_read_enable) begin
        check("rd_addr", 32'(o_rb_read_addr), 32'(mon_addr));
        check("rb_enable_in_read", 32'(o_rb_enable), 32'd1);
        mon_addr++;
      end
      if (o_tx_start) begin
        if (first) check("first_byte_latency", 32'(cyc - start_cyc), 32'd3);
        first = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_byte_extra: got %h expected none", o_tx_data);
        end else check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        bytes_seen++;
      end
      if (o_done) done_cnt++;
    end
  end

  localparam int BYTES_PER_DUMP =
`ifdef REG_DUMP_CHECKSUM_EN
    129;
`else
    128;
`endif

  task automatic push_dump();
    logic [7:0] x = '0;
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(regs[r][b*8 +: 8]);
        x ^= regs[r][b*8 +: 8];
      end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start   = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input string name);
    for (int i = 0; i < 3000 && bytes_seen < target; i++) @(negedge clk);
    check(name, 32'(bytes_seen >= target), 32'd1);
  endtask

  task automatic finish_dump(input int b0, input int d0, input string tag);
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_byte_count"}, 32'(bytes_seen - b0), 32'(BYTES_PER_DUMP));
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_rb_en"}, 32'(o_rb_enable), 32'd0);
    check({tag, "_rb_ren"}, 32'(o_rb_read_enable), 32'd0);
    check({tag, "_rb_addr"}, 32'(o_rb_read_addr), 32'd0);
    check({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int b0, d0;
    rst = 1'b1;
    i_start = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'h0102_0300 + 32'(k);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full dump: 01 02 03 00 ... 01 02 03 1F
    push_dump();
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    check("rb_enable_after_start", 32'(o_rb_enable), 32'd1);
    finish_dump(b0, d0, "dump1");

    // Start pulsed again during byte 60 is ignored
    push_dump();
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    wait_bytes(b0 + 60, "reach_byte60");
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    finish_dump(b0, d0, "dump2");

    // i_tx_done in IDLE and coincident with o_tx_start is ignored
    regs[0] = 32'hDEAD_BEEF;
    tx_auto = 1'b0;
    @(negedge clk); tx_req++;
    repeat (3) @(negedge clk);
    check("idle_done_busy", 32'(o_busy), 32'd0);
    push_dump();
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    @(negedge clk); tx_req++;
    @(negedge clk);
    check("coincident_start", 32'(o_tx_start), 32'd1);
    check("coincident_done", 32'(tx_done), 32'd1);
    repeat (8) @(negedge clk);
    check("hold_tx_data", 32'(o_tx_data), 32'hDE);
    check("hold_no_restart", 32'(o_tx_start), 32'd0);
    check("hold_busy", 32'(o_busy), 32'd1);
    check("hold_one_byte", 32'(bytes_seen - b0), 32'd1);
    tx_auto = 1'b1;
    tx_req++;
    finish_dump(b0, d0, "dump3");

    // Reset while waiting on byte 10, then a clean restart
    regs[0] = 32'h0102_0300;
    push_dump();
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    wait_bytes(b0 + 10, "reach_byte10");
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    push_dump();
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    finish_dump(b0, d0, "dump4");

`ifdef REG_DUMP_CHECKSUM_EN
    for (int k = 0; k < 32; k++) regs[k] = 32'h1111_1111;
    for (int i = 0; i < 128; i++) exp_q.push_back(8'h11);
    exp_q.push_back(8'h00);
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    finish_dump(b0, d0, "chk_zero");
    regs[5] = 32'h0000_00FF;
    for (int i = 0; i < 128; i++) exp_q.push_back((i >= 20 && i < 23) ? 8'h00 : (i == 23) ? 8'hFF : 8'h11);
    exp_q.push_back(8'hFF);
    b0 = bytes_seen; d0 = done_cnt;
    pulse_start();
    finish_dump(b0, d0, "chk_ff");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
